// File: rtl/core_types_pkg.sv
// Shared types and constants for the rename-stage free list.
// Contents:
//   - Sizing constants: architectural/physical register counts, free list
//     depth, lane widths, checkpoint columns, ROB index width.
//   - phys_reg_tag_t, ROB_index_t, checkpoint_column_t, free_count_t.
//   - free_list_ptr_t: a FIFO pointer {index, msb}. The msb toggles on every
//     rollover, so tail - head distinguishes full from empty.
//   - ptr_value / ptr_advance helpers for modulo-2*DEPTH pointer arithmetic.
package core_types_pkg;

    localparam int NUM_ARCH_REGS      = 32;
    localparam int NUM_PHYS_REGS      = 64;
    localparam int FREE_LIST_DEPTH    = 32;
    localparam int DEQ_WIDTH          = 2;
    localparam int ENQ_WIDTH          = 2;
    localparam int CHECKPOINT_COLUMNS = 4;
    localparam int ROB_INDEX_WIDTH    = 6;

    localparam int TAG_WIDTH    = $clog2(NUM_PHYS_REGS);
    localparam int INDEX_WIDTH  = $clog2(FREE_LIST_DEPTH);
    localparam int COLUMN_WIDTH = $clog2(CHECKPOINT_COLUMNS);
    localparam int COUNT_WIDTH  = INDEX_WIDTH + 1;

    typedef logic [TAG_WIDTH-1:0]       phys_reg_tag_t;
    typedef logic [ROB_INDEX_WIDTH-1:0] ROB_index_t;
    typedef logic [COLUMN_WIDTH-1:0]    checkpoint_column_t;
    typedef logic [COUNT_WIDTH-1:0]     free_count_t;

    typedef struct packed {
        logic [INDEX_WIDTH-1:0] index;
        logic                   msb;
    } free_list_ptr_t;

    // Pointer as a plain number in [0, 2*DEPTH), msb on top.
    function automatic free_count_t ptr_value(input free_list_ptr_t p);
        return {p.msb, p.index};
    endfunction

    // Advance a pointer; index wraps modulo DEPTH and msb toggles on rollover.
    function automatic free_list_ptr_t ptr_advance(input free_list_ptr_t p,
                                                   input free_count_t n);
        free_count_t    v;
        free_list_ptr_t r;
        v       = ptr_value(p) + n;
        r.index = v[INDEX_WIDTH-1:0];
        r.msb   = v[INDEX_WIDTH];
        return r;
    endfunction

endpackage

// File: rtl/free_list_checkpoint_table.sv
// Checkpoint table of saved free-list head pointers, tagged by ROB index.
// Ports:
//   CLK, nRST                    clock, asynchronous active-low reset
//   save_valid/ROB_index/head    save request, tag and head to store
//   save_ready                   tail column free and no rollback this cycle
//   save_column                  tail column (written on a save)
//   restore_valid/speculate_failed/ROB_index/column
//                                rollback (failed=1) or release (failed=0)
//   restore_success              column valid and ROB index matches
//   rollback                     a successful rollback is happening now
//   restore_head                 head pointer saved in the restore column
module free_list_checkpoint_table
    import core_types_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,
    input  logic               save_valid,
    input  ROB_index_t         save_ROB_index,
    input  free_list_ptr_t     save_head,
    output logic               save_ready,
    output checkpoint_column_t save_column,
    input  logic               restore_valid,
    input  logic               restore_speculate_failed,
    input  ROB_index_t         restore_ROB_index,
    input  checkpoint_column_t restore_column,
    output logic               restore_success,
    output logic               rollback,
    output free_list_ptr_t     restore_head
);

    logic [CHECKPOINT_COLUMNS-1:0] column_valid;
    ROB_index_t                    column_ROB_index [CHECKPOINT_COLUMNS];
    free_list_ptr_t                column_head      [CHECKPOINT_COLUMNS];
    checkpoint_column_t            tail_column;
    checkpoint_column_t            span;
    logic [CHECKPOINT_COLUMNS-1:0] kill_mask;

    assign restore_success = column_valid[restore_column] &&
                             (column_ROB_index[restore_column] == restore_ROB_index);
    assign rollback        = restore_valid && restore_speculate_failed && restore_success;
    assign save_ready      = !column_valid[tail_column] && !rollback;
    assign save_column     = tail_column;
    assign restore_head    = column_head[restore_column];

    // Columns from the restored one up to tail-1 are younger checkpoints on
    // the mispredicted path. A span of zero with a valid restore column means
    // the table is completely full, so every column goes.
    always_comb begin
        checkpoint_column_t col;
        col       = '0;
        kill_mask = '0;
        span      = tail_column - restore_column;
        for (int i = 0; i < CHECKPOINT_COLUMNS; i++) begin
            col = restore_column + checkpoint_column_t'(i);
            if (span == '0 || checkpoint_column_t'(i) < span) begin
                kill_mask[col] = 1'b1;
            end
        end
    end

    // Rollback overrides everything. Otherwise a release is applied first and
    // a save afterwards, so a save to the same column wins.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            column_valid <= '0;
            tail_column  <= '0;
            for (int i = 0; i < CHECKPOINT_COLUMNS; i++) begin
                column_ROB_index[i] <= '0;
                column_head[i]      <= '0;
            end
        end else if (rollback) begin
            column_valid <= column_valid & ~kill_mask;
            tail_column  <= restore_column;
        end else begin
            if (restore_valid && !restore_speculate_failed && restore_success) begin
                column_valid[restore_column] <= 1'b0;
            end
            if (save_valid && save_ready) begin
                column_valid[tail_column]     <= 1'b1;
                column_ROB_index[tail_column] <= save_ROB_index;
                column_head[tail_column]      <= save_head;
                tail_column                   <= tail_column + checkpoint_column_t'(1);
            end
        end
    end

endmodule

// File: rtl/phys_reg_free_list_mp.sv
// Multi-lane physical register free list for a superscalar rename stage.
// Circular FIFO of free tags: up to DEQ_WIDTH tags out per cycle to rename,
// up to ENQ_WIDTH freed tags in per cycle from commit, plus checkpointed head
// pointers for single-cycle mispredict rollback.
// Ports:
//   CLK, nRST                   clock, asynchronous active-low reset
//   dequeue_req/ready/phys_reg_tag   rename allocation lanes
//   enqueue_valid/phys_reg_tag  commit free lanes
//   full, empty, free_count     occupancy status
//   overflow_error              sticky, an enqueue lane was dropped
//   save_checkpoint_*           checkpoint save interface
//   restore_checkpoint_*        checkpoint rollback/release interface
module phys_reg_free_list_mp
    import core_types_pkg::*;
(
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [DEQ_WIDTH-1:0]   dequeue_req,
    output logic                   dequeue_ready,
    output phys_reg_tag_t          dequeue_phys_reg_tag [DEQ_WIDTH],
    input  logic [ENQ_WIDTH-1:0]   enqueue_valid,
    input  phys_reg_tag_t          enqueue_phys_reg_tag [ENQ_WIDTH],
    output logic                   full,
    output logic                   empty,
    output free_count_t            free_count,
    output logic                   overflow_error,
    input  logic                   save_checkpoint_valid,
    input  ROB_index_t             save_checkpoint_ROB_index,
    output logic                   save_checkpoint_ready,
    output checkpoint_column_t     save_checkpoint_safe_column,
    input  logic                   restore_checkpoint_valid,
    input  logic                   restore_checkpoint_speculate_failed,
    input  ROB_index_t             restore_checkpoint_ROB_index,
    input  checkpoint_column_t     restore_checkpoint_safe_column,
    output logic                   restore_checkpoint_success
);

    phys_reg_tag_t          tag_array [FREE_LIST_DEPTH];
    free_list_ptr_t         head;
    free_list_ptr_t         tail;
    free_list_ptr_t         head_after_dequeue;
    free_list_ptr_t         restore_head;
    free_count_t            dequeue_count;
    free_count_t            accept_count;
    free_count_t            enqueue_room;
    free_count_t            enqueue_count;
    logic [ENQ_WIDTH-1:0]   enqueue_accept;
    logic [INDEX_WIDTH-1:0] enqueue_index [ENQ_WIDTH];
    logic                   enqueue_drop;
    logic                   rollback;

    assign free_count    = ptr_value(tail) - ptr_value(head);
    assign full          = (free_count == free_count_t'(FREE_LIST_DEPTH));
    assign empty         = (free_count == '0);
    assign dequeue_ready = (free_count >= free_count_t'(DEQ_WIDTH)) && !rollback;

    // Requested lanes are compacted onto consecutive entries from head.
    // Idle lanes show head+k, which is what they would get if all lanes asked.
    always_comb begin
        free_count_t offset;
        offset = '0;
        for (int k = 0; k < DEQ_WIDTH; k++) begin
            if (dequeue_req[k]) begin
                dequeue_phys_reg_tag[k] = tag_array[head.index + offset[INDEX_WIDTH-1:0]];
                offset = offset + free_count_t'(1);
            end else begin
                dequeue_phys_reg_tag[k] = tag_array[head.index + INDEX_WIDTH'(k)];
            end
        end
        dequeue_count      = offset;
        accept_count       = dequeue_ready ? dequeue_count : '0;
        head_after_dequeue = ptr_advance(head, accept_count);
    end

    // Room counts entries this cycle's dequeue frees up. Lanes are accepted
    // lowest first, so anything dropped is always the highest valid lanes.
    always_comb begin
        free_count_t used;
        used           = '0;
        enqueue_accept = '0;
        enqueue_drop   = 1'b0;
        enqueue_room   = free_count_t'(FREE_LIST_DEPTH) - free_count + accept_count;
        for (int k = 0; k < ENQ_WIDTH; k++) begin
            enqueue_index[k] = tail.index + used[INDEX_WIDTH-1:0];
            if (enqueue_valid[k]) begin
                if (used < enqueue_room) begin
                    enqueue_accept[k] = 1'b1;
                    used = used + free_count_t'(1);
                end else begin
                    enqueue_drop = 1'b1;
                end
            end
        end
        enqueue_count = used;
    end

    // Tag storage and pointers. The list resets full of the non-architectural
    // tags; enqueue is applied even while a rollback moves head.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < FREE_LIST_DEPTH; i++) begin
                tag_array[i] <= phys_reg_tag_t'(NUM_ARCH_REGS + i);
            end
            head           <= '{index: '0, msb: 1'b0};
            tail           <= '{index: '0, msb: 1'b1};
            overflow_error <= 1'b0;
        end else begin
            for (int k = 0; k < ENQ_WIDTH; k++) begin
                if (enqueue_accept[k]) begin
                    tag_array[enqueue_index[k]] <= enqueue_phys_reg_tag[k];
                end
            end
            tail <= ptr_advance(tail, enqueue_count);
            head <= rollback ? restore_head : head_after_dequeue;
            if (enqueue_drop) begin
                overflow_error <= 1'b1;
            end
        end
    end

    free_list_checkpoint_table u_checkpoint_table (
        .CLK                      (CLK),
        .nRST                     (nRST),
        .save_valid               (save_checkpoint_valid),
        .save_ROB_index           (save_checkpoint_ROB_index),
        .save_head                (head_after_dequeue),
        .save_ready               (save_checkpoint_ready),
        .save_column              (save_checkpoint_safe_column),
        .restore_valid            (restore_checkpoint_valid),
        .restore_speculate_failed (restore_checkpoint_speculate_failed),
        .restore_ROB_index        (restore_checkpoint_ROB_index),
        .restore_column           (restore_checkpoint_safe_column),
        .restore_success          (restore_checkpoint_success),
        .rollback                 (rollback),
        .restore_head             (restore_head)
    );

endmodule
